anabellek_obek_getirici: RTL and testbench

ANABELLEK_OBEK_GETIRICI -- requirements
Module: anabellek_obek_getirici

---
 rtl/anabellek_obek_getirici_pkg.sv | 16 +
 rtl/anabellek_obek_getirici.sv | 139 +++++++++++++
 tb/tb_anabellek_obek_getirici.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/anabellek_obek_getirici_pkg.sv
// Shared types and constants for the instruction-cache block fetcher.
// Holds the FSM state encoding and the block geometry.
package anabellek_obek_getirici_pkg;

    localparam int unsigned OBEK_KELIME = 4;
    localparam int unsigned KELIME_W    = 32;
    localparam int unsigned OBEK_W      = OBEK_KELIME * KELIME_W;
    localparam int unsigned ADRES_W     = 32;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        OKU   = 2'd1,
        TAMAM = 2'd2
    } durum_e;

endpackage

// File: rtl/anabellek_obek_getirici.sv
// Fetches one 4-word cache block from main memory word by word after a miss,
// with per-word timeout and abort, and publishes the block on completion.
module anabellek_obek_getirici
    import anabellek_obek_getirici_pkg::*;
#(
    parameter int unsigned ZAMAN_ASIMI = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                istek_i,
    input  logic [ADRES_W-1:0]  istek_adres_i,
    input  logic                iptal_i,
    output logic                istek_hazir_o,
    output logic                bellek_istek_o,
    output logic [ADRES_W-1:0]  bellek_adres_o,
    input  logic [KELIME_W-1:0] bellek_veri_i,
    input  logic                bellek_gecerli_i,
    output logic [OBEK_W-1:0]   buyruk_obek_o,
    output logic                anabellekten_obek_geldi_o,
    output logic [ADRES_W-1:0]  onbellek_yaz_adres_o,
    output logic                hata_o
);

    localparam int unsigned ZW = $clog2(ZAMAN_ASIMI + 1);
    localparam logic [1:0]  SON_KELIME = 2'(OBEK_KELIME - 1);

    durum_e              durum_q, durum_d;
    logic [1:0]          sayac_q, sayac_d;
    logic [ZW-1:0]       zaman_q, zaman_d;
    logic [ADRES_W-1:0]  blok_adres_q, blok_adres_d;
    logic [OBEK_W-1:0]   obek_q, obek_d;
    logic [OBEK_W-1:0]   buyruk_q, buyruk_d;
    logic [ADRES_W-1:0]  yaz_adres_q, yaz_adres_d;
    logic [ADRES_W-1:0]  bellek_adres_q, bellek_adres_d;
    logic                hazir_q, hazir_d;
    logic                bellek_istek_q, bellek_istek_d;
    logic                geldi_q, geldi_d;
    logic                hata_q, hata_d;

    // State register and all registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q        <= BOSTA;
            sayac_q        <= '0;
            zaman_q        <= '0;
            blok_adres_q   <= '0;
            obek_q         <= '0;
            buyruk_q       <= '0;
            yaz_adres_q    <= '0;
            bellek_adres_q <= '0;
            hazir_q        <= 1'b1;
            bellek_istek_q <= 1'b0;
            geldi_q        <= 1'b0;
            hata_q         <= 1'b0;
        end else begin
            durum_q        <= durum_d;
            sayac_q        <= sayac_d;
            zaman_q        <= zaman_d;
            blok_adres_q   <= blok_adres_d;
            obek_q         <= obek_d;
            buyruk_q       <= buyruk_d;
            yaz_adres_q    <= yaz_adres_d;
            bellek_adres_q <= bellek_adres_d;
            hazir_q        <= hazir_d;
            bellek_istek_q <= bellek_istek_d;
            geldi_q        <= geldi_d;
            hata_q         <= hata_d;
        end
    end

    // Next state, word assembly and timeout; abort beats data and timeout
    always_comb begin
        durum_d        = durum_q;
        sayac_d        = sayac_q;
        zaman_d        = zaman_q;
        blok_adres_d   = blok_adres_q;
        obek_d         = obek_q;
        buyruk_d       = buyruk_q;
        yaz_adres_d    = yaz_adres_q;
        bellek_adres_d = bellek_adres_q;
        hazir_d        = hazir_q;
        bellek_istek_d = bellek_istek_q;
        geldi_d        = 1'b0;
        hata_d         = 1'b0;

        case (durum_q)
            BOSTA: begin
                if (istek_i && !iptal_i) begin
                    blok_adres_d   = istek_adres_i & 32'hFFFF_FFF0;
                    bellek_adres_d = istek_adres_i & 32'hFFFF_FFF0;
                    sayac_d        = '0;
                    zaman_d        = '0;
                    durum_d        = OKU;
                end
            end
            OKU: begin
                if (iptal_i) begin
                    durum_d = BOSTA;
                end else if (bellek_gecerli_i) begin
                    obek_d[{sayac_q, 5'd0} +: KELIME_W] = bellek_veri_i;
                    zaman_d = '0;
                    sayac_d = sayac_q + 2'd1;
                    if (sayac_q == SON_KELIME) begin
                        durum_d     = TAMAM;
                        buyruk_d    = obek_d;
                        yaz_adres_d = blok_adres_q;
                    end else begin
                        bellek_adres_d = {blok_adres_q[31:4], sayac_d, 2'b00};
                    end
                end else begin
                    zaman_d = zaman_q + ZW'(1);
                    if (zaman_d == ZW'(ZAMAN_ASIMI)) begin
                        hata_d  = 1'b1;
                        durum_d = BOSTA;
                    end
                end
            end
            TAMAM: begin
                durum_d = BOSTA;
            end
            default: begin
                durum_d = BOSTA;
            end
        endcase

        hazir_d        = (durum_d == BOSTA);
        bellek_istek_d = (durum_d == OKU);
        geldi_d        = (durum_d == TAMAM);
    end

    assign istek_hazir_o             = hazir_q;
    assign bellek_istek_o            = bellek_istek_q;
    assign bellek_adres_o            = bellek_adres_q;
    assign buyruk_obek_o             = buyruk_q;
    assign anabellekten_obek_geldi_o = geldi_q;
    assign onbellek_yaz_adres_o      = yaz_adres_q;
    assign hata_o                    = hata_q;

endmodule

// File: tb/tb_anabellek_obek_getirici.sv
// Bench for the block fetcher: directed vector table, hand-written corner
// sequences and randomized transactions against a transaction-level model.
module tb_anabellek_obek_getirici;

    localparam int unsigned ZA = 8;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         istek_i;
    logic [31:0]  istek_adres_i;
    logic         iptal_i;
    logic         istek_hazir_o;
    logic         bellek_istek_o;
    logic [31:0]  bellek_adres_o;
    logic [31:0]  bellek_veri_i;
    logic         bellek_gecerli_i;
    logic [127:0] buyruk_obek_o;
    logic         anabellekten_obek_geldi_o;
    logic [31:0]  onbellek_yaz_adres_o;
    logic         hata_o;

    anabellek_obek_getirici #(.ZAMAN_ASIMI(ZA)) dut (
        .clk_i                     (clk_i),
        .rst_i                     (rst_i),
        .istek_i                   (istek_i),
        .istek_adres_i             (istek_adres_i),
        .iptal_i                   (iptal_i),
        .istek_hazir_o             (istek_hazir_o),
        .bellek_istek_o            (bellek_istek_o),
        .bellek_adres_o            (bellek_adres_o),
        .bellek_veri_i             (bellek_veri_i),
        .bellek_gecerli_i          (bellek_gecerli_i),
        .buyruk_obek_o             (buyruk_obek_o),
        .anabellekten_obek_geldi_o (anabellekten_obek_geldi_o),
        .onbellek_yaz_adres_o      (onbellek_yaz_adres_o),
        .hata_o                    (hata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0]      adr;
        logic [3:0][4:0]  gap;       // idle cycles before each word
        logic [31:0]      w0;        // word k is w0 + k
        logic [2:0]       abort_at;  // 4 = no abort
        logic             abort_v;   // abort cycle also carries a valid word
        logic             ipt_tamam; // assert iptal while the pulse is out
        logic             exp_geldi;
        logic             exp_hata;
        logic [7:0]       exp_lat;
        logic [127:0]     exp_blk;
        logic [31:0]      exp_yaz;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    logic [31:0]  cur_w   [4];
    int           cur_gap [4];
    int           cur_ab;
    bit           cur_abv;
    bit           cur_ipt;
    int           r_geldi, r_hata, r_lat;
    logic [127:0] r_blk;
    logic [31:0]  r_yaz;
    logic [127:0] ref_blk;
    logic [31:0]  ref_yaz;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Drives one request with the memory schedule in cur_*; returns observations
    task automatic run_txn(input logic [31:0] adr, input string nm);
        logic [31:0] base;
        int          cyc;
        int          n;
        bit          stop;
        bit          to;
        bit          last;
        base = adr & 32'hFFFF_FFF0;
        chk($sformatf("%s_hazir_start", nm), 128'(istek_hazir_o), 128'(1));
        istek_i       = 1'b1;
        istek_adres_i = adr;
        step();
        cyc           = 1;
        istek_i       = 1'b0;
        istek_adres_i = $urandom;
        stop          = 1'b0;
        for (int k = 0; k < 4 && !stop; k++) begin
            to = (cur_gap[k] >= int'(ZA));
            n  = to ? int'(ZA) : cur_gap[k] + 1;
            for (int g = 0; g < n; g++) begin
                chk($sformatf("%s_req_w%0d", nm, k), 128'(bellek_istek_o), 128'(1));
                chk($sformatf("%s_adr_w%0d", nm, k), 128'(bellek_adres_o), 128'(base + 32'(4 * k)));
                chk($sformatf("%s_nopulse_w%0d", nm, k),
                    128'({anabellekten_obek_geldi_o, hata_o}), 128'(0));
                last             = !to && (g == n - 1);
                bellek_gecerli_i = last && ((cur_ab != k) || cur_abv);
                bellek_veri_i    = last ? cur_w[k] : $urandom;
                iptal_i          = last && (cur_ab == k);
                step();
                cyc++;
            end
            bellek_gecerli_i = 1'b0;
            iptal_i          = 1'b0;
            stop             = to || (cur_ab == k);
        end
        r_geldi = 0;
        r_hata  = 0;
        r_lat   = 0;
        for (int o = 0; o < 3; o++) begin
            if (o == 0) begin
                chk($sformatf("%s_req_off", nm), 128'(bellek_istek_o), 128'(0));
                r_blk = buyruk_obek_o;
                r_yaz = onbellek_yaz_adres_o;
            end
            if (o == 1) chk($sformatf("%s_hazir_end", nm), 128'(istek_hazir_o), 128'(1));
            if (anabellekten_obek_geldi_o) begin
                r_geldi++;
                r_lat   = cyc;
                iptal_i = cur_ipt;
            end
            if (hata_o) r_hata++;
            bellek_gecerli_i = 1'b1;
            bellek_veri_i    = $urandom;
            step();
            cyc++;
            iptal_i          = 1'b0;
            bellek_gecerli_i = 1'b0;
        end
    endtask

    task automatic compare(input string nm, input bit eg, input bit eh, input int el,
                           input logic [127:0] eb, input logic [31:0] ey);
        chk($sformatf("%s_geldi_cnt", nm), 128'(r_geldi), 128'(eg));
        chk($sformatf("%s_hata_cnt", nm), 128'(r_hata), 128'(eh));
        if (eg) chk($sformatf("%s_latency", nm), 128'(r_lat), 128'(el));
        chk($sformatf("%s_blok", nm), r_blk, eb);
        chk($sformatf("%s_yaz_adres", nm), 128'(r_yaz), 128'(ey));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [8];
        logic [31:0] adr;
        bit          eg, eh;
        int          el;

        vt[0] = '{adr:32'h0000_1234, gap:{5'd0, 5'd0, 5'd0, 5'd0}, w0:32'hA0, abort_at:3'd4,
                  abort_v:1'b0, ipt_tamam:1'b0, exp_geldi:1'b1, exp_hata:1'b0, exp_lat:8'd5,
                  exp_blk:128'h000000A3_000000A2_000000A1_000000A0, exp_yaz:32'h0000_1230};
        vt[1] = '{adr:32'h2000_0ABC, gap:{5'd3, 5'd3, 5'd3, 5'd3}, w0:32'hDEAD_0000, abort_at:3'd4,
                  abort_v:1'b0, ipt_tamam:1'b1, exp_geldi:1'b1, exp_hata:1'b0, exp_lat:8'd17,
                  exp_blk:128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000, exp_yaz:32'h2000_0AB0};
        vt[2] = '{adr:32'h5555_5555, gap:{5'd0, 5'd0, 5'd0, 5'd31}, w0:32'h1, abort_at:3'd4,
                  abort_v:1'b0, ipt_tamam:1'b0, exp_geldi:1'b0, exp_hata:1'b1, exp_lat:8'd0,
                  exp_blk:128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000, exp_yaz:32'h2000_0AB0};
        vt[3] = '{adr:32'h0000_0800, gap:{5'd0, 5'd0, 5'd0, 5'd0}, w0:32'h11, abort_at:3'd2,
                  abort_v:1'b0, ipt_tamam:1'b0, exp_geldi:1'b0, exp_hata:1'b0, exp_lat:8'd0,
                  exp_blk:128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000, exp_yaz:32'h2000_0AB0};
        vt[4] = '{adr:32'h0000_0040, gap:{5'd0, 5'd2, 5'd0, 5'd1}, w0:32'h4000_0000, abort_at:3'd4,
                  abort_v:1'b0, ipt_tamam:1'b0, exp_geldi:1'b1, exp_hata:1'b0, exp_lat:8'd8,
                  exp_blk:128'h40000003_40000002_40000001_40000000, exp_yaz:32'h0000_0040};
        vt[5] = '{adr:32'h9000_0010, gap:{5'd0, 5'd0, 5'd0, 5'd0}, w0:32'h55, abort_at:3'd3,
                  abort_v:1'b1, ipt_tamam:1'b0, exp_geldi:1'b0, exp_hata:1'b0, exp_lat:8'd0,
                  exp_blk:128'h40000003_40000002_40000001_40000000, exp_yaz:32'h0000_0040};
        vt[6] = '{adr:32'h0000_0077, gap:{5'd0, 5'd8, 5'd0, 5'd0}, w0:32'h66, abort_at:3'd4,
                  abort_v:1'b0, ipt_tamam:1'b0, exp_geldi:1'b0, exp_hata:1'b1, exp_lat:8'd0,
                  exp_blk:128'h40000003_40000002_40000001_40000000, exp_yaz:32'h0000_0040};
        vt[7] = '{adr:32'hFFFF_FFFF, gap:{5'd0, 5'd0, 5'd7, 5'd7}, w0:32'hC0, abort_at:3'd4,
                  abort_v:1'b0, ipt_tamam:1'b0, exp_geldi:1'b1, exp_hata:1'b0, exp_lat:8'd19,
                  exp_blk:128'h000000C3_000000C2_000000C1_000000C0, exp_yaz:32'hFFFF_FFF0};

        rst_i = 1'b1; istek_i = 1'b0; istek_adres_i = '0; iptal_i = 1'b0;
        bellek_veri_i = '0; bellek_gecerli_i = 1'b0;
        step();
        chk("rst_hazir", 128'(istek_hazir_o), 128'(1));
        chk("rst_req", 128'(bellek_istek_o), 128'(0));
        chk("rst_adr", 128'(bellek_adres_o), 128'(0));
        chk("rst_blok", buyruk_obek_o, 128'(0));
        chk("rst_yaz", 128'(onbellek_yaz_adres_o), 128'(0));
        chk("rst_pulses", 128'({anabellekten_obek_geldi_o, hata_o}), 128'(0));
        rst_i = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) begin
                cur_gap[k] = int'(vt[i].gap[k]);
                cur_w[k]   = vt[i].w0 + 32'(k);
            end
            cur_ab  = int'(vt[i].abort_at);
            cur_abv = vt[i].abort_v;
            cur_ipt = vt[i].ipt_tamam;
            run_txn(vt[i].adr, $sformatf("v%0d", i));
            compare($sformatf("v%0d", i), vt[i].exp_geldi, vt[i].exp_hata, int'(vt[i].exp_lat),
                    vt[i].exp_blk, vt[i].exp_yaz);
        end
        ref_blk = vt[7].exp_blk;
        ref_yaz = vt[7].exp_yaz;

        // istek together with iptal in BOSTA must not be accepted
        istek_i = 1'b1; iptal_i = 1'b1; istek_adres_i = 32'h0000_1111;
        step();
        istek_i = 1'b0; iptal_i = 1'b0;
        chk("both_hazir", 128'(istek_hazir_o), 128'(1));
        chk("both_req", 128'(bellek_istek_o), 128'(0));
        step();
        chk("both_req2", 128'(bellek_istek_o), 128'(0));

        // Stray valid words while idle leave the published block alone
        for (int i = 0; i < 3; i++) begin
            bellek_gecerli_i = 1'b1; bellek_veri_i = $urandom;
            step();
        end
        bellek_gecerli_i = 1'b0;
        chk("stray_blok", buyruk_obek_o, ref_blk);
        chk("stray_geldi", 128'(anabellekten_obek_geldi_o), 128'(0));

        // Reset while word 2 is being returned
        istek_i = 1'b1; istek_adres_i = 32'h0000_3330;
        step();
        istek_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bellek_gecerli_i = 1'b1; bellek_veri_i = 32'(k + 1);
            step();
        end
        chk("rmid_adr_w2", 128'(bellek_adres_o), 128'(32'h0000_3338));
        rst_i = 1'b1; bellek_gecerli_i = 1'b1; bellek_veri_i = 32'h3;
        step();
        rst_i = 1'b0; bellek_gecerli_i = 1'b0;
        chk("rmid_hazir", 128'(istek_hazir_o), 128'(1));
        chk("rmid_outs", {bellek_istek_o, anabellekten_obek_geldi_o, hata_o, bellek_adres_o,
                          onbellek_yaz_adres_o}, 128'(0));
        chk("rmid_blok", buyruk_obek_o, 128'(0));
        ref_blk = '0;
        ref_yaz = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("rmid_quiet%0d", i), 128'({bellek_istek_o, anabellekten_obek_geldi_o}),
                128'(0));
        end

        // Randomized transactions against the transaction-level model
        for (int t = 0; t < 40; t++) begin
            adr = $urandom;
            for (int k = 0; k < 4; k++) begin
                cur_gap[k] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(ZA, ZA + 3))
                                                         : int'($urandom_range(0, 4));
                cur_w[k]   = $urandom;
            end
            cur_ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : 4;
            cur_abv = 1'($urandom_range(0, 1));
            cur_ipt = 1'($urandom_range(0, 1));
            eg = 1'b1; eh = 1'b0; el = 1;
            for (int k = 0; k < 4; k++) begin
                if (cur_gap[k] >= int'(ZA)) begin
                    eg = 1'b0; eh = 1'b1;
                    break;
                end
                if (cur_ab == k) begin
                    eg = 1'b0;
                    break;
                end
                el += cur_gap[k] + 1;
            end
            if (eg) begin
                ref_blk = {cur_w[3], cur_w[2], cur_w[1], cur_w[0]};
                ref_yaz = adr & 32'hFFFF_FFF0;
            end
            run_txn(adr, $sformatf("r%0d", t));
            compare($sformatf("r%0d", t), eg, eh, el, ref_blk, ref_yaz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
